// File: rtl/rw_arb_pkg.sv
// Shared types for the two-requester read/write arbiter.
//   state_t  : arbiter FSM states
//   req_id_t : requester index (two requesters -> one bit)
//   TIMER_W  : width of the per-attempt timeout counter
package rw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef logic req_id_t;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   valid[1:0] : pending requests
//   last       : requester granted most recently
//   grant[1:0] : one-hot grant, all zero when nothing is valid
//   id         : index of the granted requester
module rr_arb2
  import rw_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output logic [1:0] grant,
  output req_id_t    id
);

  always_comb begin
    id    = 1'b0;
    grant = 2'b00;
    if (&valid) begin
      // Tie: the requester that was not served last wins.
      id = ~last;
    end else if (valid[1]) begin
      id = 1'b1;
    end
    if (|valid) begin
      grant[id] = 1'b1;
    end
  end

endmodule

// File: rtl/rw_arbiter.sv
// Arbitrates two requesters onto a single read/write engine.
// One transfer is in flight at a time: IDLE grants round-robin, ISSUE fires
// the engine start pulse, WAIT watches for the matching success pulse under a
// timeout with bounded retries, RESP returns a one-cycle completion.
// Ports:
//   clock, reset                     : clock, async active-high reset
//   req_valid/req_write[1:0]         : per-requester request and direction
//   req_mempage[1:0], req_wdata[1:0] : per-requester page and write payload
//   req_ready[1:0]                   : acceptance strobe (IDLE only)
//   rsp_done/rsp_ok[1:0], rsp_rdata  : completion pulse, status, read data
//   read_start/write_start           : engine start pulses
//   read_mempage/write_mempage       : latched page operand
//   write_data                       : latched write payload
//   read_success/write_success       : engine success pulses
//   read_data                        : engine read result
module rw_arbiter
  import rw_arb_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_write,
  input  logic [1:0][15:0] req_mempage,
  input  logic [1:0][63:0] req_wdata,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_done,
  output logic [1:0]       rsp_ok,
  output logic [63:0]      rsp_rdata,
  output logic             read_start,
  output logic             write_start,
  output logic [15:0]      read_mempage,
  output logic [15:0]      write_mempage,
  output logic [63:0]      write_data,
  input  logic             read_success,
  input  logic             write_success,
  input  logic [63:0]      read_data
);

  localparam int RETRY_W = 3;

  state_t               state, state_nxt;
  req_id_t              last_q, gnt_id_q;
  logic                 wr_q;
  logic [15:0]          page_q;
  logic [63:0]          wdata_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 ok_q;
  logic [1:0]           rr_grant;
  req_id_t              rr_id;
  logic                 match;
  logic                 can_retry;

  rr_arb2 u_rr (
    .valid (req_valid),
    .last  (last_q),
    .grant (rr_grant),
    .id    (rr_id)
  );

  // Only the pulse for the operation in flight counts; the other is noise.
  assign match     = wr_q ? write_success : read_success;
  assign can_retry = (retry_q < RETRY_W'(MAX_RETRY));

  assign read_mempage  = page_q;
  assign write_mempage = page_q;
  assign write_data    = wdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 2'b00;
    rsp_done    = 2'b00;
    rsp_ok      = 2'b00;
    read_start  = 1'b0;
    write_start = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rr_grant;
        if (|req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        read_start  = ~wr_q;
        write_start = wr_q;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // Success is tested first so it wins over a coincident expiry.
        if (match)               state_nxt = RESP;
        else if (timer_q == '0)  state_nxt = can_retry ? ISSUE : RESP;
      end
      RESP: begin
        rsp_done[gnt_id_q] = 1'b1;
        rsp_ok[gnt_id_q]   = ok_q;
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer context, timer, retry count and response data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      gnt_id_q  <= 1'b0;
      wr_q      <= 1'b0;
      page_q    <= '0;
      wdata_q   <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      ok_q      <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt_id_q <= rr_id;
            wr_q     <= req_write[rr_id];
            page_q   <= req_mempage[rr_id];
            wdata_q  <= req_wdata[rr_id];
            retry_q  <= '0;
          end
        end
        ISSUE: timer_q <= TIMER_W'(TIMEOUT);
        WAIT: begin
          if (match) begin
            ok_q      <= 1'b1;
            rsp_rdata <= wr_q ? 64'd0 : read_data;
          end else if (timer_q == '0) begin
            if (can_retry) begin
              retry_q <= retry_q + 1'b1;
            end else begin
              ok_q      <= 1'b0;
              rsp_rdata <= '0;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        RESP: last_q <= gnt_id_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_arbiter.sv
module tb_rw_arbiter;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_write;
  logic [1:0][15:0] req_mempage;
  logic [1:0][63:0] req_wdata;
  logic [1:0]       req_ready, rsp_done, rsp_ok;
  logic [63:0]      rsp_rdata;
  logic             read_start, write_start;
  logic [15:0]      read_mempage, write_mempage;
  logic [63:0]      write_data;
  logic             read_success, write_success;
  logic [63:0]      read_data;

  int n_cmp = 0;
  int n_err = 0;

  rw_arbiter #(.MAX_RETRY(2), .TIMEOUT(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_mempage   (req_mempage),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_done      (rsp_done),
    .rsp_ok        (rsp_ok),
    .rsp_rdata     (rsp_rdata),
    .read_start    (read_start),
    .write_start   (write_start),
    .read_mempage  (read_mempage),
    .write_mempage (write_mempage),
    .write_data    (write_data),
    .read_success  (read_success),
    .write_success (write_success),
    .read_data     (read_data)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 2'b00;
    req_write     = 2'b00;
    req_mempage   = '0;
    req_wdata     = '0;
    read_success  = 1'b0;
    write_success = 1'b0;
    read_data     = '0;

    // ---- reset state
    step(); step();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_done", rsp_done, 2'b00);
    chk("rst_ok", rsp_ok, 2'b00);
    chk("rst_starts", {read_start, write_start}, 2'b00);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_pages", {read_mempage, write_mempage}, 32'd0);
    chk("rst_wdata", write_data, 64'd0);
    reset = 1'b0;
    step();

    // ---- single read, success 5 cycles after read_start
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_mempage[0] = 16'h0012;
    #1 chk("rd_ready", req_ready, 2'b01);
    step();                                  // cycle 1: ISSUE
    req_valid = 2'b00;                       // dropping valid must not matter
    chk("rd_start", {read_start, write_start}, 2'b10);
    chk("rd_rpage", read_mempage, 16'h0012);
    chk("rd_wpage", write_mempage, 16'h0012);
    step();                                  // cycle 2
    chk("rd_start_once", read_start, 1'b0);
    step(); step(); step(); step();          // cycle 6
    read_success = 1'b1;
    read_data    = 64'hDEADBEEF_0BADF00D;
    step();                                  // cycle 7: RESP
    read_success = 1'b0;
    chk("rd_done", rsp_done, 2'b01);
    chk("rd_ok", rsp_ok, 2'b01);
    chk("rd_rdata", rsp_rdata, 64'hDEADBEEF_0BADF00D);
    step();
    chk("rd_done_pulse", rsp_done, 2'b00);
    chk("rd_no_restart", read_start, 1'b0);

    // ---- simultaneous requests after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    req_valid      = 2'b11;
    req_write      = 2'b01;
    req_mempage[0] = 16'h0100;
    req_wdata[0]   = 64'h1111_2222_3333_4444;
    req_mempage[1] = 16'h0200;
    #1 chk("tie_ready0", req_ready, 2'b01);
    step();                                  // ISSUE for req0 write
    chk("tie_wstart", {read_start, write_start}, 2'b01);
    chk("tie_wdata", write_data, 64'h1111_2222_3333_4444);
    chk("tie_wpage", write_mempage, 16'h0100);
    step();                                  // WAIT
    write_success = 1'b1;
    step();                                  // RESP
    write_success = 1'b0;
    chk("tie_done0", rsp_done, 2'b01);
    chk("tie_ok0", rsp_ok, 2'b01);
    chk("tie_rdata0", rsp_rdata, 64'd0);
    chk("tie_resp_noready", req_ready, 2'b00);
    step();                                  // IDLE: req1 wins the tie
    chk("tie_ready1", req_ready, 2'b10);
    step();
    chk("tie_rstart1", {read_start, write_start}, 2'b10);
    chk("tie_rpage1", read_mempage, 16'h0200);
    step();
    read_success = 1'b1;
    read_data    = 64'h0000_0000_2222_2222;
    step();
    read_success = 1'b0;
    chk("tie_done1", rsp_done, 2'b10);
    chk("tie_ok1", rsp_ok, 2'b10);
    chk("tie_rdata1", rsp_rdata, 64'h0000_0000_2222_2222);
    step();                                  // IDLE: tie goes back to req0
    chk("tie_ready_next", req_ready, 2'b01);
    req_valid = 2'b00;
    #1 chk("idle_noreq", req_ready, 2'b00);

    // ---- retry exhaustion: three write_start pulses, 10 cycles apart
    step();
    req_valid      = 2'b01;
    req_write      = 2'b01;
    req_mempage[0] = 16'h0300;
    step();                                  // cycle 1: ISSUE
    req_valid = 2'b00;
    chk("rt_ws1", write_start, 1'b1);
    for (int i = 2; i <= 31; i++) begin
      step();
      chk($sformatf("rt_ws_c%0d", i), write_start, (i == 11 || i == 21));
    end
    chk("rt_done", rsp_done, 2'b01);
    chk("rt_ok", rsp_ok, 2'b00);
    chk("rt_rdata", rsp_rdata, 64'd0);
    step();

    // ---- success coincides with timer expiry
    req_valid      = 2'b10;
    req_write      = 2'b00;
    req_mempage[1] = 16'h0400;
    #1 chk("ex_ready", req_ready, 2'b10);
    step();                                  // cycle 1: ISSUE
    req_valid = 2'b00;
    for (int i = 2; i <= 10; i++) step();    // cycle 10: timer at zero
    read_success = 1'b1;
    read_data    = 64'h3333_3333_3333_3333;
    step();                                  // cycle 11
    read_success = 1'b0;
    chk("ex_done", rsp_done, 2'b10);
    chk("ex_ok", rsp_ok, 2'b10);
    chk("ex_rdata", rsp_rdata, 64'h3333_3333_3333_3333);
    chk("ex_no_reissue", read_start, 1'b0);
    step();

    // ---- stray write_success during a read, then reset in WAIT
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_mempage[0] = 16'h0500;
    step();                                  // cycle 1: ISSUE
    req_valid = 2'b00;
    step();                                  // cycle 2
    write_success = 1'b1;
    step();                                  // cycle 3
    write_success = 1'b0;
    chk("st_no_done", rsp_done, 2'b00);
    for (int i = 4; i <= 11; i++) step();
    chk("st_reissue", read_start, 1'b1);
    step();                                  // cycle 12: WAIT
    reset = 1'b1;
    #1;
    chk("wr_rst_page", read_mempage, 16'h0000);
    chk("wr_rst_rdata", rsp_rdata, 64'd0);
    chk("wr_rst_outs", {req_ready, rsp_done, rsp_ok, read_start, write_start}, 8'd0);
    step();
    reset        = 1'b0;
    read_success = 1'b1;
    read_data    = 64'h5555;
    step();
    read_success = 1'b0;
    chk("post_rst_no_done", rsp_done, 2'b00);
    chk("post_rst_no_start", {read_start, write_start}, 2'b00);
    step();
    chk("post_rst_no_done2", rsp_done, 2'b00);
    req_valid      = 2'b11;
    req_write      = 2'b11;
    req_wdata[0]   = 64'h0A0A;
    req_wdata[1]   = 64'h0B0B;
    #1 chk("post_rst_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("post_rst_wstart", write_start, 1'b1);
    chk("post_rst_wdata", write_data, 64'h0A0A);
    step();
    write_success = 1'b1;
    step();
    write_success = 1'b0;
    chk("post_rst_done", rsp_done, 2'b01);
    chk("post_rst_ok", rsp_ok, 2'b01);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
